alu_result_stage: RTL

- Registered output stage directly downstream of the 8-bit ALU datapath (adder, logic unit, barrel shift-left/right).
- Captures the ALU result with its opcode and operands, and derives the Z/N/C/V flags.
- Presents result and flags to the register-file/writeback side through a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered. Also maintains sticky flags and a transfer counter.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_result_stage_if.sv | 27 ++
 rtl/alu_flag_gen.sv | 48 ++++
 rtl/alu_result_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and flag vector type for the ALU result path.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int FLG_Z   = 3;
  localparam int FLG_N   = 2;
  localparam int FLG_C   = 1;
  localparam int FLG_V   = 0;
  localparam int FLAGS_W = 4;

  typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-side input bus and writeback-side output bus of the result stage.
// master = ALU/writeback environment, slave = the result stage.
interface alu_result_stage_if #(parameter int W = 8);
  import alu_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  flags_t       out_flags;

  modport master (
    output in_valid, in_op, in_a, in_b, in_y, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_y, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from opcode, operands and the ALU result.
// Z/N always come from y; C/V depend on the opcode, shift amount is b[2:0].
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] y_i,
  output flags_t       flags_o
);

  localparam logic [W-1:0] ONE_W = W'(1);

  logic [2:0]   sh;
  logic [W-1:0] shl_mask;
  logic [W-1:0] shr_mask;
  logic         add_c;

  assign sh = b_i[2:0];
  // Bit shifted out last: a[W-s] for SHL, a[s-1] for SHR; both masks vanish when s==0.
  assign shl_mask = ONE_W << (W - int'(sh));
  assign shr_mask = (ONE_W << sh) >> 1;
  // a+b overflows W bits exactly when a exceeds the one's complement of b.
  assign add_c = (a_i > ~b_i);

  always_comb begin
    flags_o        = '0;
    flags_o[FLG_Z] = (y_i == '0);
    flags_o[FLG_N] = y_i[W-1];
    case (op_i)
      OP_ADD: begin
        flags_o[FLG_C] = add_c;
        flags_o[FLG_V] = (a_i[W-1] == b_i[W-1]) && (y_i[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        flags_o[FLG_C] = (a_i < b_i);
        flags_o[FLG_V] = (a_i[W-1] != b_i[W-1]) && (y_i[W-1] != a_i[W-1]);
      end
      OP_SHL:  flags_o[FLG_C] = |(a_i & shl_mask);
      OP_SHR:  flags_o[FLG_C] = |(a_i & shr_mask);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer (main M, skid S), registered in_ready,
// flags captured at input, sticky flags and wrapping transfer counter on output transfers.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus,
  input  logic               clr_sticky,
  output flags_t             sticky_flags,
  output logic [CNT_W-1:0]   xfer_cnt
);

  flags_t in_flags;

  alu_flag_gen #(.W(W)) u_flag_gen (
    .op_i    (bus.in_op),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .y_i     (bus.in_y),
    .flags_o (in_flags)
  );

  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic             in_rdy_q, in_rdy_d;
  logic [W-1:0]     m_y_q, m_y_d;
  logic [W-1:0]     s_y_q, s_y_d;
  flags_t           m_flg_q, m_flg_d;
  flags_t           s_flg_q, s_flg_d;
  flags_t           sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid && in_rdy_q;
  assign out_xfer = m_vld_q && bus.out_ready;

  always_comb begin
    m_vld_d  = m_vld_q;
    s_vld_d  = s_vld_q;
    m_y_d    = m_y_q;
    s_y_d    = s_y_q;
    m_flg_d  = m_flg_q;
    s_flg_d  = s_flg_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (!m_vld_q) begin
      if (in_xfer) begin
        m_vld_d = 1'b1;
        m_y_d   = bus.in_y;
        m_flg_d = in_flags;
      end
    end else if (out_xfer) begin
      // in_ready is low whenever S is full, so S draining and an input never coincide.
      if (s_vld_q) begin
        m_y_d   = s_y_q;
        m_flg_d = s_flg_q;
        s_vld_d = 1'b0;
      end else if (in_xfer) begin
        m_y_d   = bus.in_y;
        m_flg_d = in_flags;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      s_vld_d = 1'b1;
      s_y_d   = bus.in_y;
      s_flg_d = in_flags;
    end

    in_rdy_d = !s_vld_d;

    // Clear wins over accumulation but the flags of a coincident transfer survive.
    if (clr_sticky) begin
      sticky_d = out_xfer ? m_flg_q : '0;
    end else if (out_xfer) begin
      sticky_d = sticky_q | m_flg_q;
    end

    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      in_rdy_q <= 1'b1;
      m_y_q    <= '0;
      s_y_q    <= '0;
      m_flg_q  <= '0;
      s_flg_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      in_rdy_q <= in_rdy_d;
      m_y_q    <= m_y_d;
      s_y_q    <= s_y_d;
      m_flg_q  <= m_flg_d;
      s_flg_q  <= s_flg_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = m_vld_q;
  assign bus.out_y     = m_y_q;
  assign bus.out_flags = m_flg_q;
  assign sticky_flags  = sticky_q;
  assign xfer_cnt      = cnt_q;

endmodule
